// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory-port arbiter.
// Holds the FSM state encoding, owner encoding, beat address step and winner-selection helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Byte distance between consecutive words of a line burst.
    localparam int unsigned BEAT_INCR = 4;

    // A lone requester always wins; on a tie the cache that did not own last time goes first.
    function automatic owner_t rr_winner(input logic ic_req, input logic dc_req,
                                         input owner_t last_owner);
        owner_t w;
        if (ic_req && dc_req) begin
            w = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (dc_req) begin
            w = OWN_D;
        end else begin
            w = OWN_I;
        end
        return w;
    endfunction

    function automatic owner_t prio_winner(input logic dc_req);
        return dc_req ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arb_beat_counter.sv
// Beat counter for one line burst: tracks the current word index, flags the last
// word and forms the byte address of the current beat from the line base.
module mem_arb_beat_counter
    import mem_arb_pkg::*;
#(
    parameter  int WORD_SIZE  = 32,
    parameter  int BLOCK_SIZE = 4,
    localparam int BEAT_W     = $clog2(BLOCK_SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [WORD_SIZE-1:0] base,
    output logic [BEAT_W-1:0]    beat,
    output logic                 last,
    output logic [WORD_SIZE-1:0] addr
);

    logic [BEAT_W-1:0] beat_reg;

    // The count saturates on the last word so it can never wrap inside a burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_reg <= '0;
        end else if (clear) begin
            beat_reg <= '0;
        end else if (advance && !last) begin
            beat_reg <= beat_reg + 1'b1;
        end
    end

    assign beat = beat_reg;
    assign last = (beat_reg == BEAT_W'(BLOCK_SIZE - 1));
    assign addr = base + (WORD_SIZE'(beat_reg) * WORD_SIZE'(BEAT_INCR));

endmodule

// File: rtl/mem_arbiter.sv
// Line-burst arbiter sharing one memory port between the I-cache and D-cache.
// Define MEM_ARB_DCACHE_PRIO_EN for fixed D-cache priority; otherwise round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 ic_req,
    input  logic [WORD_SIZE-1:0] ic_addr,
    output logic                 ic_grant,
    output logic [WORD_SIZE-1:0] ic_rdata,
    output logic                 ic_valid,
    output logic                 ic_done,

    input  logic                 dc_req,
    input  logic                 dc_write,
    input  logic [WORD_SIZE-1:0] dc_addr,
    input  logic [WORD_SIZE-1:0] dc_wdata,
    output logic                 dc_grant,
    output logic [WORD_SIZE-1:0] dc_rdata,
    output logic                 dc_valid,
    output logic                 dc_done,

    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready
);

    localparam int BEAT_W = $clog2(BLOCK_SIZE);
    localparam logic [WORD_SIZE-1:0] LINE_MASK = WORD_SIZE'(BLOCK_SIZE * BEAT_INCR - 1);

    arb_state_t           state_reg, state_next;
    owner_t               owner_reg, owner_next;
    owner_t               winner;
    logic                 op_reg, op_next;
    logic [WORD_SIZE-1:0] base_reg, base_next;
    logic                 start;

    logic                 beat_clear;
    logic                 beat_advance;
    logic [BEAT_W-1:0]    beat;
    logic                 beat_last;
    logic [WORD_SIZE-1:0] beat_addr;
    logic                 beat_unused;

    assign start = (state_reg == IDLE) && (ic_req || dc_req);

`ifdef MEM_ARB_DCACHE_PRIO_EN
    assign winner = prio_winner(dc_req);
`else
    owner_t last_owner_reg;

    // Reset to D so that the first contested request is served for the I-cache.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_owner_reg <= OWN_D;
        end else if (start) begin
            last_owner_reg <= winner;
        end
    end

    assign winner = rr_winner(ic_req, dc_req, last_owner_reg);
`endif

    mem_arb_beat_counter #(
        .WORD_SIZE  (WORD_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_beat_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (beat_clear),
        .advance (beat_advance),
        .base    (base_reg),
        .beat    (beat),
        .last    (beat_last),
        .addr    (beat_addr)
    );

    assign beat_unused = ^beat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= OWN_I;
            op_reg    <= 1'b0;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            op_reg    <= op_next;
            base_reg  <= base_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        op_next      = op_reg;
        base_next    = base_reg;
        beat_clear   = 1'b0;
        beat_advance = 1'b0;
        ic_grant     = 1'b0;
        dc_grant     = 1'b0;
        ic_done      = 1'b0;
        dc_done      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    owner_next = winner;
                    // Only a D-cache burst can be a write-back; I-cache bursts are always reads.
                    op_next    = (winner == OWN_D) && dc_write;
                    base_next  = ((winner == OWN_D) ? dc_addr : ic_addr) & ~LINE_MASK;
                    beat_clear = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                ic_grant  = (owner_reg == OWN_I);
                dc_grant  = (owner_reg == OWN_D);
                mem_read  = !op_reg;
                mem_write = op_reg;
                mem_addr  = beat_addr;
                mem_wdata = dc_wdata;
                if (mem_ready) begin
                    beat_advance = 1'b1;
                    if (beat_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                ic_grant   = (owner_reg == OWN_I);
                dc_grant   = (owner_reg == OWN_D);
                ic_done    = (owner_reg == OWN_I);
                dc_done    = (owner_reg == OWN_D);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-owner return path: valid pulses the cycle after a completed beat.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_owner
            logic                 beat_hit;
            logic                 valid_reg;
            logic [WORD_SIZE-1:0] rdata_reg;

            assign beat_hit = (state_reg == BUSY) && mem_ready
                              && (owner_reg == owner_t'(1'(gi)));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    valid_reg <= beat_hit;
                    if (beat_hit && !op_reg) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign ic_valid = g_owner[0].valid_reg;
    assign ic_rdata = g_owner[0].rdata_reg;
    assign dc_valid = g_owner[1].valid_reg;
    assign dc_rdata = g_owner[1].rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int WS = 32;
    localparam int BS = 4;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0, dc_req = 1'b0, dc_write = 1'b0, mem_ready = 1'b0;
    logic [WS-1:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata = '0;
    logic          ic_grant, ic_valid, ic_done, dc_grant, dc_valid, dc_done, mem_read, mem_write;
    logic [WS-1:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

    mem_arbiter #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) dut (
        .clock(clock), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_rdata(ic_rdata),
        .ic_valid(ic_valid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_grant(dc_grant), .dc_rdata(dc_rdata), .dc_valid(dc_valid), .dc_done(dc_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_busy = 0, m_fin = 0, m_wr = 0, m_ivalid = 0, m_dvalid = 0;
    int            m_owner = 0, m_last = 1, m_nbeats = 0, ntxn = 0;
    logic [31:0]   m_base = '0, m_irdata = '0, m_drdata = '0;
    logic [31:0]   wlog[$];

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                m_busy = 0; m_fin = 0; m_wr = 0; m_ivalid = 0; m_dvalid = 0;
                m_owner = 0; m_last = 1; m_nbeats = 0;
                m_base = '0; m_irdata = '0; m_drdata = '0;
                continue;
            end
            chk("ic_grant", ic_grant, (m_busy || m_fin) && m_owner == 0);
            chk("dc_grant", dc_grant, (m_busy || m_fin) && m_owner == 1);
            chk("mem_read", mem_read, m_busy && !m_wr);
            chk("mem_write", mem_write, m_busy && m_wr);
            chk("mem_addr", mem_addr, m_busy ? (m_base + 32'(4 * m_nbeats)) : 32'h0);
            chk("mem_wdata", mem_wdata, m_busy ? dc_wdata : 32'h0);
            chk("ic_valid", ic_valid, m_ivalid);
            chk("dc_valid", dc_valid, m_dvalid);
            chk("ic_done", ic_done, m_fin && m_owner == 0);
            chk("dc_done", dc_done, m_fin && m_owner == 1);
            chk("ic_rdata", ic_rdata, m_irdata);
            chk("dc_rdata", dc_rdata, m_drdata);

            m_ivalid = 0;
            m_dvalid = 0;
            if (m_busy) begin
                if (mem_ready) begin
                    if (m_wr) wlog.push_back(mem_wdata);
                    if (m_owner == 0) begin
                        m_ivalid = 1; m_irdata = mem_rdata;
                    end else begin
                        m_dvalid = 1;
                        if (!m_wr) m_drdata = mem_rdata;
                    end
                    m_nbeats++;
                    if (m_nbeats == BS) begin m_busy = 0; m_fin = 1; end
                end
            end else if (m_fin) begin
                m_fin = 0;
                ntxn++;
                $display("txn %0d owner=%s op=%s base=%08h", ntxn, (m_owner == 1) ? "D" : "I",
                         m_wr ? "write" : "read", m_base);
            end else if (ic_req || dc_req) begin
                int w;
                if (ic_req && dc_req) w = PRIO ? 1 : ((m_last == 1) ? 0 : 1);
                else w = dc_req ? 1 : 0;
                m_last = w;
                m_owner = w;
                m_wr = (w == 1) && dc_write;
                m_base = ((w == 1) ? dc_addr : ic_addr) & ~(32'(BS * 4) - 32'd1);
                m_nbeats = 0;
                m_busy = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ic_grant || dc_grant) && n < 40) begin
            step();
            n++;
        end
        chk("idle_reached", ic_grant || dc_grant, 0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int starts[$];
        logic [31:0] sent[$];
        bit pi, pd, got;
        int nval, bad, c_last, c_done, first_c;

        // Reset state
        step(); step();
        chk("rst_ic_grant", ic_grant, 0); chk("rst_dc_grant", dc_grant, 0);
        chk("rst_mem_read", mem_read, 0); chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_valids", {ic_valid, dc_valid, ic_done, dc_done}, 0);
        chk("rst_rdata", ic_rdata | dc_rdata, 0);
        reset = 1'b0;

        // Simultaneous requests right after reset
        ic_addr = 32'h1000; dc_addr = 32'h2000; dc_write = 0; mem_ready = 1;
        ic_req = 1; dc_req = 1;
        pi = 0; pd = 0; first_c = -1;
        for (int c = 0; c < 40 && (ic_req || dc_req); c++) begin
            step();
            if (ic_grant && !pi) order.push_back(0);
            if (dc_grant && !pd) order.push_back(1);
            if ((ic_grant || dc_grant) && first_c < 0) first_c = c;
            pi = ic_grant; pd = dc_grant;
            if (ic_done) ic_req = 0;
            if (dc_done) dc_req = 0;
        end
        chk("t3_grant_latency", first_c, 0);
        chk("t3_count", order.size(), 2);
        chk("t3_first", order.size() > 0 ? order[0] : 9, PRIO ? 1 : 0);
        chk("t3_second", order.size() > 1 ? order[1] : 9, PRIO ? 0 : 1);
        wait_idle();

        // I-cache line read, non-aligned address, mem_ready tied high
        order.delete();
        ic_addr = 32'h0000_0104; ic_req = 1; mem_ready = 1;
        nval = 0; got = 0; c_last = -1; c_done = -1;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (ic_valid) begin
                nval++;
                chk("t1_rdata", ic_rdata, sent.size() > 0 ? sent.pop_front() : 32'hDEAD_BEEF);
            end
            if (ic_done) begin got = 1; c_done = c; ic_req = 0; end
            mem_rdata = $urandom;
            if (mem_read && ic_grant) begin
                order.push_back(int'(mem_addr));
                sent.push_back(mem_rdata);
                c_last = c;
            end
        end
        chk("t1_done_seen", got, 1);
        chk("t1_beats", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t1_addr", i < order.size() ? order[i] : 0, 32'h100 + 32'(4 * i));
        chk("t1_valids", nval, 4);
        chk("t1_done_timing", c_done, c_last + 1);
        wait_idle();

        // D-cache write-back, mem_ready every third cycle
        wlog.delete();
        dc_addr = 32'h200; dc_write = 1; dc_wdata = 32'hA000_0000; dc_req = 1; mem_ready = 0;
        nval = 0; got = 0; bad = 0;
        for (int c = 0; c < 80 && !got; c++) begin
            step();
            mem_ready = (c % 3 == 2);
            if (dc_grant && !mem_write && !dc_done) bad++;
            if (dc_valid) begin nval++; dc_wdata = 32'hA000_0000 + 32'(nval); end
            if (dc_done) begin got = 1; dc_req = 0; dc_write = 0; end
        end
        chk("t2_done_seen", got, 1);
        chk("t2_valids", nval, 4);
        chk("t2_write_held", bad, 0);
        chk("t2_wlog_size", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t2_wdata", i < wlog.size() ? wlog[i] : 0, 32'hA000_0000 + 32'(i));
        mem_ready = 1;
        wait_idle();

        // Both requesters held continuously
        order.delete(); starts.delete();
        ic_addr = 32'h3000; dc_addr = 32'h4000; ic_req = 1; dc_req = 1; pi = 0; pd = 0;
        for (int c = 0; c < 100 && order.size() < 4; c++) begin
            step();
            if (ic_grant && !pi) begin order.push_back(0); starts.push_back(c); end
            if (dc_grant && !pd) begin order.push_back(1); starts.push_back(c); end
            pi = ic_grant; pd = dc_grant;
        end
        ic_req = 0; dc_req = 0;
        chk("t4_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t4_owner", i < order.size() ? order[i] : 9, PRIO ? 1 : (i % 2));
        for (int i = 1; i < 4; i++)
            chk("t4_spacing", i < starts.size() ? starts[i] - starts[i-1] : 0, BS + 2);
        wait_idle();

        // mem_ready while idle has no effect
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            bad += int'(ic_valid) + int'(dc_valid) + int'(ic_done) + int'(dc_done)
                 + int'(mem_read) + int'(mem_write);
        end
        chk("t5_quiet", bad, 0);
        ic_addr = 32'h40C; ic_req = 1;
        step();
        chk("t5_first_addr", mem_addr, 32'h400);
        chk("t5_first_read", mem_read, 1);
        for (int c = 0; c < 20 && ic_req; c++) begin
            step();
            if (ic_done) ic_req = 0;
        end
        wait_idle();

        // Reset during beat 2
        ic_addr = 32'h300; ic_req = 1; got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            step();
            if (mem_read && mem_addr == 32'h308) got = 1;
            else mem_ready = 1'($urandom_range(0, 1));
        end
        chk("t6_beat2_seen", got, 1);
        #1 reset = 1;
        #1;
        chk("t6_rst_mem_read", mem_read, 0);
        chk("t6_rst_grants", {ic_grant, dc_grant}, 0);
        ic_req = 0;
        step(); step();
        reset = 0; ic_req = 1; mem_ready = 1;
        step();
        chk("t6_restart_addr", mem_addr, 32'h300);
        chk("t6_restart_grant", ic_grant, 1);
        for (int c = 0; c < 20 && ic_req; c++) begin
            step();
            if (ic_done) ic_req = 0;
        end
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            step();
            mem_ready = ($urandom_range(0, 9) < 6);
            mem_rdata = $urandom;
            if (dc_valid) dc_wdata = $urandom;
            if (ic_req) begin
                if (ic_done || (ic_grant && $urandom_range(0, 49) == 0)) ic_req = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                ic_req = 1; ic_addr = $urandom;
            end
            if (dc_req) begin
                if (dc_done || (dc_grant && $urandom_range(0, 49) == 0)) begin
                    dc_req = 0; dc_write = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dc_req = 1; dc_addr = $urandom; dc_write = 1'($urandom_range(0, 1));
                dc_wdata = $urandom;
            end
        end
        ic_req = 0; dc_req = 0; dc_write = 0;
        for (int c = 0; c < 20; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
